uart_echo_top: RTL and testbench
================================

Name: uart_echo_top

Overview:
- Top-level UART echo block: 8N1 serial receiver, 8N1 serial transmitter and a small control unit that echoes every received byte back on tx.
- Shows the last valid received byte on led, flags echo processing on analiza, and pulses dataSent when an echoed frame finishes.
- Sits at the FPGA pin boundary.

Parameters:
- BAUD_DIV, 326, system clocks per 16x-oversampling tick (50 MHz / (9600*16)); must be >= 1.
- DATA_BITS, 8, data bits per frame.
- OVS, 16, oversampling ticks per bit.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- rx  input  1  serial input; idle high; asynchronous to clock.
- tx  output  1  serial output; idle high.
- led  output  8  last byte received with a valid stop bit.
- dataSent  output  1  one-cycle pulse when the tx stop bit completes.
- analiza  output  1  high from valid byte reception until the echo transmission starts.

Behaviour:
- Reset (reset==0 at a clock edge) sets outputs and state as follows:
  - tx=1, led=0x00, dataSent=0, analiza=0.
  - All FSMs go to IDLE and all counters clear.
  - Applies mid-frame: a partial rx or tx frame is abandoned, tx returns high the next cycle, and no dataSent is issued.
- Tick generator:
  - Counter 0..BAUD_DIV-1; tick is a one-cycle pulse when it wraps.
  - Free-running; cleared only by reset.
- rx is passed through a 2-flop synchronizer before use.
- RX FSM:
  - IDLE: wait for synchronized rx==0 → START, tick count=0.
  - START: after 7 ticks (mid start bit) resample. If rx==0 → DATA, else it is a glitch → IDLE.
  - DATA: sample every 16 ticks, LSB first, shifting into an 8-bit shift register. After 8 samples → STOP.
  - STOP: sample after 16 ticks.
    - rx==1: rx_done pulse (1 cycle) with the byte → IDLE.
    - rx==0: framing error; byte discarded; wait for rx==1 before IDLE.
- Control:
  - On rx_done, led is loaded with the byte the same edge and the byte is written to a 1-entry pending register with pending=1.
  - A new rx_done while pending=1 overwrites the pending byte; the old byte is dropped.
  - When TX is IDLE and pending=1, issue tx_start for one cycle and clear pending.
  - analiza = pending (high from the cycle after rx_done until the tx_start cycle).
- TX FSM (bit length 16 ticks):
  - IDLE: tx=1. On tx_start, latch the byte → START.
  - START: tx=0 for 16 ticks.
  - DATA: 8 bits LSB first, 16 ticks each.
  - STOP: tx=1 for 16 ticks. At its end, dataSent=1 for exactly one clock → IDLE.
- Latency: echo start bit begins ≤2 cycles after rx_done when TX is idle.
- Simultaneous rx_done and TX finishing STOP: the pending byte is written and sent on the following cycle.
- Continuous or low-rate rx toggling (noise) must never drive tx low unless a valid stop bit was sampled.

Decomposition:
- Shared package uart_pkg holds:
  - Defaults for OVS, DATA_BITS and BAUD_DIV.
  - RX/TX state enums: IDLE, START, DATA, STOP.
- One natural sub-module: uart_baud_tick (tick generator, parameter BAUD_DIV).
- RX FSM, TX FSM and control stay in uart_echo_top.

Test Plan:
- Reset held low 5 cycles with rx=1 → tx=1, led=0x00, dataSent=0, analiza=0 throughout.
- BAUD_DIV=1, drive frame 0x55 (bit=16 clocks) →
  - led=0x55 after the stop sample; analiza high ≥1 cycle.
  - tx emits start, 1,0,1,0,1,0,1,0, stop (16 clocks each).
  - dataSent pulses once, 1 cycle, at the end of stop.
- rx low for 5 ticks then high (glitch) → no led change, tx stays 1, no dataSent.
- Frame 0xA3 with stop bit=0 → led unchanged, no echo; a following valid 0x3C is received and echoed correctly.
- Back-to-back frames 0x12, 0x34, 0x56 at full rate → all three echoed in order, 3 dataSent pulses, led ends 0x56.
- Reset asserted mid-tx-frame of 0xFF → tx=1 next cycle, no dataSent, a subsequent 0x01 is echoed normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART echo slice: default frame/baud parameters,
// FSM state encodings and a counter-width helper.
package uart_pkg;

  localparam int unsigned OVS_DEF       = 16;
  localparam int unsigned DATA_BITS_DEF = 8;
  localparam int unsigned BAUD_DIV_DEF  = 326;

  // Common state encoding for the RX and TX frame FSMs
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((n > 1) && ((32'd1 << w) < n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick at 16x the bit rate.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_echo_top.sv
// 8N1 UART echo: oversampled receiver, transmitter and a one-entry pending
// buffer that sends every good byte straight back out on tx.
module uart_echo_top
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned OVS       = OVS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] led,
  output logic                 dataSent,
  output logic                 analiza
);

  localparam int unsigned OVS_W = cnt_width(OVS);
  localparam int unsigned BIT_W = cnt_width(DATA_BITS);
  localparam logic [OVS_W-1:0] CNT_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] CNT_HALF = OVS_W'(OVS / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic tick;
  logic rx_meta, rx_sync;

  logic [1:0]           rx_state, rx_state_nxt;
  logic [OVS_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0]     rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                 rx_ferr, rx_ferr_nxt;
  logic                 rx_done_c;

  logic [1:0]           tx_state, tx_state_nxt;
  logic [OVS_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_nxt;
  logic                 data_sent, data_sent_nxt;
  logic                 tx_start_c;

  logic                 pending;
  logic [DATA_BITS-1:0] pend_data;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; idles high so reset never fakes a start bit
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_ferr  <= rx_ferr_nxt;
    end
  end

  // Receiver: mid-bit sampling; a low stop bit parks in STOP until the line idles
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_ferr_nxt  = rx_ferr;
    rx_done_c    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (!rx_sync) begin
          rx_state_nxt = ST_START;
          rx_cnt_nxt   = '0;
          rx_ferr_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt_nxt   = '0;
            rx_bit_nxt   = '0;
            rx_state_nxt = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_nxt = rx_cnt + OVS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) rx_state_nxt = ST_STOP;
            else                    rx_bit_nxt   = rx_bit + BIT_W'(1);
          end else begin
            rx_cnt_nxt = rx_cnt + OVS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (rx_ferr) begin
          if (rx_sync) begin
            rx_ferr_nxt  = 1'b0;
            rx_state_nxt = ST_IDLE;
          end
        end else if (tick) begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt_nxt = '0;
            if (rx_sync) begin
              rx_done_c    = 1'b1;
              rx_state_nxt = ST_IDLE;
            end else begin
              rx_ferr_nxt = 1'b1;
            end
          end else begin
            rx_cnt_nxt = rx_cnt + OVS_W'(1);
          end
        end
      end
      default: rx_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_start_c = pending && (tx_state == ST_IDLE);

  // Pending slot: a fresh byte wins over a stale one, even while TX takes the old
  always_ff @(posedge clock) begin
    if (!reset) begin
      led       <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
    end else if (rx_done_c) begin
      led       <= rx_shift;
      pend_data <= rx_shift;
      pending   <= 1'b1;
    end else if (tx_start_c) begin
      pending <= 1'b0;
    end
  end

  assign analiza = pending;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx        <= 1'b1;
      data_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_bit    <= tx_bit_nxt;
      tx_shift  <= tx_shift_nxt;
      tx        <= tx_nxt;
      data_sent <= data_sent_nxt;
    end
  end

  // Transmitter: tx is registered, so each bit value is set on the edge that starts it
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_cnt_nxt    = tx_cnt;
    tx_bit_nxt    = tx_bit;
    tx_shift_nxt  = tx_shift;
    tx_nxt        = tx;
    data_sent_nxt = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_nxt = 1'b1;
        if (tx_start_c) begin
          tx_shift_nxt = pend_data;
          tx_cnt_nxt   = '0;
          tx_nxt       = 1'b0;
          tx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt   = '0;
            tx_bit_nxt   = '0;
            tx_nxt       = tx_shift[0];
            tx_state_nxt = ST_DATA;
          end else begin
            tx_cnt_nxt = tx_cnt + OVS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt = '0;
            if (tx_bit == BIT_LAST) begin
              tx_nxt       = 1'b1;
              tx_state_nxt = ST_STOP;
            end else begin
              tx_bit_nxt   = tx_bit + BIT_W'(1);
              tx_nxt       = tx_shift[1];
              tx_shift_nxt = {1'b0, tx_shift[DATA_BITS-1:1]};
            end
          end else begin
            tx_cnt_nxt = tx_cnt + OVS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt    = '0;
            data_sent_nxt = 1'b1;
            tx_state_nxt  = ST_IDLE;
          end else begin
            tx_cnt_nxt = tx_cnt + OVS_W'(1);
          end
        end
      end
      default: tx_state_nxt = ST_IDLE;
    endcase
  end

  assign dataSent = data_sent;

endmodule

// File: tb/tb_uart_echo_top.sv
// Scoreboard bench for uart_echo_top at BAUD_DIV=1 (16 clocks per bit).
`timescale 1ns/1ps
module tb_uart_echo_top;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] led;
  logic       dataSent;
  logic       analiza;

  int n_checks = 0;
  int n_fail   = 0;
  int ds_count = 0;
  logic an_seen = 1'b0;
  logic ds_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_echo_top #(.BAUD_DIV(1), .DATA_BITS(8), .OVS(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .led      (led),
    .dataSent (dataSent),
    .analiza  (analiza)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drives one 8N1 frame; only frames with a good stop bit are expected back
  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    if (stop_val) exp_q.push_back(d);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clock);
    end
    rx = stop_val;
    repeat (16) @(negedge clock);
  endtask

  // Echo monitor: decodes tx frames and checks them against the queue
  initial begin : tx_mon
    logic [7:0] got;
    logic [7:0] exp;
    logic       aborted;
    int         ds_at;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        got     = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < ((b == 0) ? 8 : 16) && !aborted; k++) begin
            @(negedge clock);
            if (reset !== 1'b1) aborted = 1'b1;
          end
          if (!aborted) begin
            if (b == 0)     check_eq("tx_start_bit", 32'(tx), 32'd0);
            else if (b < 9) got[b-1] = tx;
            else            check_eq("tx_stop_bit", 32'(tx), 32'd1);
          end
        end
        if (!aborted) begin
          check_eq("tx_frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq("echo_byte", 32'(got), 32'(exp));
          end
          ds_at = -1;
          for (int k = 1; k <= 12 && ds_at < 0; k++) begin
            @(negedge clock);
            if (dataSent === 1'b1) ds_at = k;
          end
          check_eq("ds_timing", 32'(ds_at), 32'd8);
        end
      end
    end
  end

  // dataSent counter, pulse-width check and analiza observation
  initial begin : ds_mon
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        if (ds_prev) check_eq("ds_width", 32'(dataSent), 32'd0);
        if (dataSent === 1'b1) ds_count++;
        if (analiza === 1'b1) an_seen = 1'b1;
        ds_prev = dataSent;
      end else begin
        ds_prev = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int waited;
    rx    = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_ds", 32'(dataSent), 32'd0);
      check_eq("rst_analiza", 32'(analiza), 32'd0);
    end
    reset = 1'b1;
    idle(20);

    an_seen = 1'b0;
    send_frame(8'h55, 1'b1);
    check_eq("led_55", 32'(led), 32'h55);
    idle(200);
    check_eq("analiza_seen", 32'(an_seen), 32'd1);
    check_eq("ds_after_55", 32'(ds_count), 32'd1);

    // Short low glitch must be rejected at the start-bit resample
    rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(200);
    check_eq("glitch_led", 32'(led), 32'h55);
    check_eq("glitch_ds", 32'(ds_count), 32'd1);

    send_frame(8'hA3, 1'b0);
    idle(200);
    check_eq("ferr_led", 32'(led), 32'h55);
    check_eq("ferr_ds", 32'(ds_count), 32'd1);
    send_frame(8'h3C, 1'b1);
    check_eq("led_3c", 32'(led), 32'h3C);
    idle(200);
    check_eq("ds_after_3c", 32'(ds_count), 32'd2);

    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    check_eq("led_56", 32'(led), 32'h56);
    idle(400);
    check_eq("ds_after_b2b", 32'(ds_count), 32'd5);

    // Reset in the middle of the 0xFF echo
    send_frame(8'hFF, 1'b1);
    waited = 0;
    while (tx !== 1'b0 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check_eq("ff_echo_started", 32'(tx), 32'd0);
    idle(40);
    reset = 1'b0;
    @(negedge clock);
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_led", 32'(led), 32'd0);
    check_eq("midrst_ds", 32'(dataSent), 32'd0);
    check_eq("midrst_analiza", 32'(analiza), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idle(300);
    check_eq("midrst_no_ds", 32'(ds_count), 32'd5);
    check_eq("midrst_tx_idle", 32'(tx), 32'd1);

    send_frame(8'h01, 1'b1);
    check_eq("led_01", 32'(led), 32'h01);
    waited = 0;
    while (exp_q.size() > 0 && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    idle(20);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("ds_total", 32'(ds_count), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
